// File: rtl/huffman_encoder.sv
// rtl/huffman_encoder.sv - packs 4-bit symbols into 6-bit MSB-first Huffman code words
// Codes are appended bit-continuously; flush pads the partial word with zeros at the LSB end.
module huffman_encoder #(
  parameter int OUT_W = 6,
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       symbol,
  input  logic             symValid,
  output logic             symReady,
  input  logic             flush,
  output logic [OUT_W-1:0] encodedData,
  output logic             outValid,
  input  logic             outReady,
  output logic             lastWord,
  output logic [2:0]       padBits,
  output logic             codeError,
  output logic             flushDone
);

  typedef enum logic [1:0] {RUN, EMIT, PAD, DONE} state_t;

  localparam logic [3:0] WORD_BITS = 4'(OUT_W);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [3:0]       count_q, count_d;
  logic             flush_pend_q, flush_pend_d;
  logic             code_error_q, code_error_d;

  logic [OUT_W-1:0] code_bits;
  logic [2:0]       code_len;
  logic             code_ok;
  logic [3:0]       pad_full;

  // Codes are stored left-aligned so insertion is a single right shift by count.
  always_comb begin
    code_bits = '0;
    code_len  = 3'd0;
    code_ok   = 1'b1;
    case (symbol)
      4'd0:    begin code_bits = 6'b100000; code_len = 3'd1; end
      4'd1:    begin code_bits = 6'b010000; code_len = 3'd4; end
      4'd2:    begin code_bits = 6'b010100; code_len = 3'd4; end
      4'd5:    begin code_bits = 6'b001000; code_len = 3'd4; end
      4'd6:    begin code_bits = 6'b001100; code_len = 3'd4; end
      4'd9:    begin code_bits = 6'b011100; code_len = 3'd4; end
      4'd10:   begin code_bits = 6'b000000; code_len = 3'd4; end
      4'd7:    begin code_bits = 6'b011010; code_len = 3'd5; end
      4'd3:    begin code_bits = 6'b011000; code_len = 3'd6; end
      4'd4:    begin code_bits = 6'b011001; code_len = 3'd6; end
      4'd8:    begin code_bits = 6'b000110; code_len = 3'd6; end
      4'd12:   begin code_bits = 6'b000111; code_len = 3'd6; end
      4'd14:   begin code_bits = 6'b000100; code_len = 3'd6; end
      4'd15:   begin code_bits = 6'b000101; code_len = 3'd6; end
      default: code_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    count_d      = count_q;
    flush_pend_d = flush_pend_q;
    code_error_d = 1'b0;
    case (state_q)
      RUN: begin
        if (flush_pend_q) begin
          state_d = (count_q != 4'd0) ? PAD : DONE;
        end else begin
          if (symValid && symReady) begin
            if (code_ok) begin
              acc_d   = acc_q | ({code_bits, {(ACC_W-OUT_W){1'b0}}} >> count_q);
              count_d = count_q + {1'b0, code_len};
              if (count_d >= WORD_BITS) state_d = EMIT;
            end else begin
              code_error_d = 1'b1;
            end
          end
          if (flush) flush_pend_d = 1'b1;
        end
      end
      EMIT: begin
        if (flush) flush_pend_d = 1'b1;
        if (outReady) begin
          acc_d   = acc_q << OUT_W;
          count_d = count_q - WORD_BITS;
          // An empty remainder after the drain needs no padded word.
          if (count_d >= WORD_BITS)  state_d = EMIT;
          else if (flush_pend_d)     state_d = (count_d != 4'd0) ? PAD : DONE;
          else                       state_d = RUN;
        end
      end
      PAD: begin
        if (outReady) begin
          acc_d   = '0;
          count_d = 4'd0;
          state_d = DONE;
        end
      end
      DONE: begin
        flush_pend_d = 1'b0;
        state_d      = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      acc_q        <= '0;
      count_q      <= 4'd0;
      flush_pend_q <= 1'b0;
      code_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      count_q      <= count_d;
      flush_pend_q <= flush_pend_d;
      code_error_q <= code_error_d;
    end
  end

  always_comb begin
    pad_full    = WORD_BITS - count_q;
    outValid    = (state_q == EMIT) || (state_q == PAD);
    symReady    = (state_q == RUN) && (count_q < WORD_BITS) && !flush_pend_q;
    encodedData = outValid ? acc_q[ACC_W-1 -: OUT_W] : '0;
    lastWord    = (state_q == PAD);
    padBits     = (state_q == PAD) ? pad_full[2:0] : 3'd0;
    codeError   = code_error_q;
    flushDone   = (state_q == DONE);
  end

endmodule
